// File: rtl/edit_mem_ll_req_arb.sv
// Round-robin arbiter sharing the linked-list next-pointer lookup port among NUM_REQ requesters.
// Outstanding lookups are tagged in an in-order FIFO so each returned pointer is routed to its issuer.
`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 8
`endif

module edit_mem_ll_req_arb #(
  parameter int NUM_REQ    = 4,
  parameter int BPTR_NBITS = `EM_BUF_PTR_NBITS,
  parameter int TAG_DEPTH  = 8,
  parameter int MAX_OUTS   = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*BPTR_NBITS-1:0]     req_ptr_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic                              buf_req_o,
  output logic [BPTR_NBITS-1:0]             buf_req_ptr_o,
  input  logic                              buf_ack_valid_i,
  input  logic [BPTR_NBITS-1:0]             buf_ack_ptr_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [BPTR_NBITS-1:0]             rsp_ptr_o,
  output logic [$clog2(TAG_DEPTH+1)-1:0]    outs_total_o,
  output logic                              err_ack_underflow_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int TW = $clog2(TAG_DEPTH+1);
  localparam int OW = $clog2(MAX_OUTS+1);
  localparam logic [OW-1:0] MAX_OUTS_V  = OW'(MAX_OUTS);
  localparam logic [TW-1:0] TAG_DEPTH_V = TW'(TAG_DEPTH);
  localparam logic [IW-1:0] LAST_REQ    = IW'(NUM_REQ-1);

  logic [IW-1:0]         rr_q, rr_d;
  logic [OW-1:0]         outs_q [NUM_REQ];
  logic [OW-1:0]         outs_d [NUM_REQ];
  logic [TW-1:0]         total_q, total_d;
  logic [AW:0]           wr_q, rd_q;
  logic [IW-1:0]         tag_mem [TAG_DEPTH];
  logic                  buf_req_q;
  logic [BPTR_NBITS-1:0] buf_req_ptr_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [BPTR_NBITS-1:0] rsp_ptr_q;
  logic                  err_q;

  logic [NUM_REQ-1:0]    elig, grant;
  logic                  grant_any;
  logic [IW-1:0]         gidx;
  logic                  fifo_empty, pop;
  logic [IW-1:0]         head_tag;

  assign fifo_empty = (wr_q == rd_q);
  assign pop        = buf_ack_valid_i && !fifo_empty;
  assign head_tag   = tag_mem[rd_q[AW-1:0]];

  // Gating with reset keeps req_ready low while reset is held.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = rst_ni && req_valid_i[i] && (outs_q[i] < MAX_OUTS_V) && (total_q < TAG_DEPTH_V);
  end

  always_comb begin
    int idx;
    grant     = '0;
    grant_any = 1'b0;
    gidx      = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        gidx      = IW'(idx);
      end
    end
    if (grant_any) grant[gidx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_any) rr_d = (gidx == LAST_REQ) ? '0 : gidx + 1'b1;
  end

  always_comb begin
    outs_d  = outs_q;
    total_d = total_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] && !(pop && head_tag == IW'(i)))
        outs_d[i] = outs_q[i] + 1'b1;
      else if (!grant[i] && pop && head_tag == IW'(i))
        outs_d[i] = outs_q[i] - 1'b1;
    end
    if (grant_any && !pop)
      total_d = total_q + 1'b1;
    else if (!grant_any && pop)
      total_d = total_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q          <= '0;
      total_q       <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      buf_req_q     <= 1'b0;
      buf_req_ptr_q <= '0;
      rsp_valid_q   <= '0;
      rsp_ptr_q     <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) outs_q[i] <= '0;
    end else begin
      rr_q        <= rr_d;
      outs_q      <= outs_d;
      total_q     <= total_d;
      buf_req_q   <= grant_any;
      rsp_valid_q <= '0;
      if (grant_any) begin
        buf_req_ptr_q <= req_ptr_i[gidx*BPTR_NBITS +: BPTR_NBITS];
        wr_q          <= wr_q + 1'b1;
      end
      if (pop) begin
        rsp_valid_q[head_tag] <= 1'b1;
        rsp_ptr_q             <= buf_ack_ptr_i;
        rd_q                  <= rd_q + 1'b1;
      end
      if (buf_ack_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  // Tag storage is pure data; the read/write pointers alone define occupancy.
  always_ff @(posedge clk_i) begin
    if (grant_any) tag_mem[wr_q[AW-1:0]] <= gidx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && grant_any) begin
      assert (outs_q[gidx] < MAX_OUTS_V && total_q < TAG_DEPTH_V);
    end
  end

  assign req_ready_o         = grant;
  assign buf_req_o           = buf_req_q;
  assign buf_req_ptr_o       = buf_req_ptr_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_ptr_o           = rsp_ptr_q;
  assign outs_total_o        = total_q;
  assign err_ack_underflow_o = err_q;

endmodule
